// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Request sequencer in front of the 64KB lower-RAM block RAM. Two masters
//   (m0 = CPU bus, m1 = DMA/video fetch) issue byte reads/writes. Requests
//   are arbitrated round-robin and driven onto the RAM's cs/we/addr/din.
//   Reads wait on ram_drdy. A read returns either data or, after TIMEOUT
//   wait cycles, an error. Every completion is a one-cycle ack.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   mN_req/we/addr/wdata      master N request. Held stable until mN_ack.
//   mN_ack/err/rdata          completion pulse, timeout flag, read data
//                             (rdata is held until the next mN read ack)
//   ram_cs/we/addr/din        RAM command outputs
//   ram_dout, ram_drdy        RAM read data and data-ready flag
//   Every output comes straight from a flop.
module bram_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_drdy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              last_q, last_d;     // master served most recently
  logic              gnt_q, gnt_d;       // master that owns the current access
  logic              ram_cs_q, ram_cs_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              pick;               // master chosen in IDLE
  logic              done;               // access completes this cycle
  logic              fail;               // completion is a read timeout

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    ram_cs_d   = ram_cs_q;
    ram_we_d   = ram_we_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    pick       = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;

    unique case (state_q)
      IDLE: begin
        ram_cs_d = 1'b0;
        ram_we_d = 1'b0;
        if (m0_req || m1_req) begin
          // On a tie, the master that was not served last wins.
          pick       = (m0_req && m1_req) ? ~last_q : m1_req;
          gnt_d      = pick;
          ram_cs_d   = 1'b1;
          ram_we_d   = pick ? m1_we    : m0_we;
          ram_addr_d = pick ? m1_addr  : m0_addr;
          ram_din_d  = pick ? m1_wdata : m0_wdata;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // ram_we_q still holds the granted master's direction here.
        if (ram_we_q) begin
          done     = 1'b1;
          ram_cs_d = 1'b0;
          ram_we_d = 1'b0;
          state_d  = RELEASE;
        end else begin
          cnt_d   = 8'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ram_drdy) begin
          done     = 1'b1;
          ram_cs_d = 1'b0;
          state_d  = RELEASE;
          if (gnt_q) m1_rdata_d = ram_dout;
          else       m0_rdata_d = ram_dout;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_C) begin
            done     = 1'b1;
            fail     = 1'b1;
            ram_cs_d = 1'b0;
            state_d  = RELEASE;
          end
        end
      end
      RELEASE: begin
        // Deliberately no timeout: a stuck drdy must stall visibly.
        ram_cs_d = 1'b0;
        if (!ram_drdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done) last_d = gnt_q;
    m0_ack_d = done & ~gnt_q;
    m1_ack_d = done &  gnt_q;
    m0_err_d = fail & ~gnt_q;
    m1_err_d = fail &  gnt_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign m0_ack   = m0_ack_q;
  assign m0_err   = m0_err_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_ack   = m1_ack_q;
  assign m1_err   = m1_err_q;
  assign m1_rdata = m1_rdata_q;
  assign ram_cs   = ram_cs_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: a behavioural block-RAM model, a table of
// transactions with expected results, and hand-written sequences for reset
// mid-read, stuck drdy and simultaneous requests. Expected acks are queued
// when a request is raised and popped by a monitor when an ack appears.
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        ram_cs, ram_we, ram_drdy;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din, ram_dout;

  int total = 0;
  int bad   = 0;

  bram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_drdy(ram_drdy)
  );

  always #5 clk = ~clk;

  // RAM model: data ready one cycle after a read select, cleared when
  // deselected. 'block' withholds drdy, 'stuck' forces it high.
  logic [7:0] mem [65536];
  logic       drdy_r = 1'b0;
  logic       block  = 1'b0;
  logic       stuck  = 1'b0;
  logic [7:0] dout_r = 8'h00;

  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_din;
    if (ram_cs && !ram_we) begin
      dout_r <= mem[ram_addr];
      drdy_r <= ~block;
    end else if (!ram_cs) begin
      drdy_r <= 1'b0;
    end
  end
  assign ram_dout = dout_r;
  assign ram_drdy = drdy_r | stuck;

  typedef struct {
    logic        m;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        blk;
    logic        err;
    logic [7:0]  rdata;
    int          lat;    // cycles from request to ack; 0 = not checked
  } vec_t;

  typedef struct {
    logic       m;
    logic       we;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] last_rd [2];
  vec_t       vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic m, input logic we, input logic [15:0] a,
                              input logic [7:0] wd, input logic blk, input logic err,
                              input logic [7:0] rd, input int lat);
    vec_t v;
    v.m = m; v.we = we; v.addr = a; v.wdata = wd; v.blk = blk;
    v.err = err; v.rdata = rd; v.lat = lat;
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.m = v.m; e.we = v.we; e.err = v.err; e.rdata = v.rdata;
    sb_q.push_back(e);
  endtask

  task automatic start_txn(input vec_t v);
    push_exp(v);
    block = v.blk;
    if (v.m) begin
      m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata; m1_req = 1'b1;
    end else begin
      m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata; m0_req = 1'b1;
    end
  endtask

  // Waits (bounded) for the granted master's ack, then drops its request.
  task automatic wait_ack(input vec_t v);
    int   lat = 0;
    logic got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && v.lat != 0) begin
        check("issue_cs", ram_cs, 1);
        check("issue_we", ram_we, v.we);
        check("issue_addr", ram_addr, v.addr);
        if (v.we) check("issue_din", ram_din, v.wdata);
      end
      if (v.m ? m1_ack : m0_ack) got = 1'b1;
    end
    check("ack_seen", got, 1);
    if (got) begin
      check("ack_cs_low", ram_cs, 0);
      check("ack_we_low", ram_we, 0);
      if (v.lat != 0) check("ack_latency", lat, v.lat);
    end
    if (v.m) m1_req = 1'b0;
    else     m0_req = 1'b0;
  endtask

  // Scoreboard monitor plus per-cycle invariants.
  always @(negedge clk) begin
    if (rst) begin
      last_rd[0] <= 8'h00;
      last_rd[1] <= 8'h00;
    end else begin
      check("one_ack", m0_ack & m1_ack, 0);
      check("we_needs_cs", ram_we & ~ram_cs, 0);
      if (m0_ack || m1_ack) begin
        check("ack_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check("ack_master", m1_ack, mon_e.m);
          check("ack_err", mon_e.m ? m1_err : m0_err, mon_e.err);
          if (!mon_e.we) begin
            if (mon_e.err) begin
              check("rdata_kept", mon_e.m ? m1_rdata : m0_rdata, last_rd[mon_e.m]);
            end else begin
              check("rdata", mon_e.m ? m1_rdata : m0_rdata, mon_e.rdata);
              last_rd[mon_e.m] <= mon_e.rdata;
            end
          end
        end
      end
    end
  end

  task automatic pulse_reset();
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    check("rst_cs", ram_cs, 0);
    check("rst_we", ram_we, 0);
    check("rst_m0_ack", m0_ack, 0);
    check("rst_m1_ack", m1_ack, 0);
    @(negedge clk);
    rst = 1'b0;
    block = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = 16'(i);
      mem[i] = a[7:0] ^ a[15:8] ^ 8'h5A;
    end

    vecs[0]  = mk(0, 0, 16'h0000, 8'h00, 0, 0, 8'h5A, 3);
    vecs[1]  = mk(0, 1, 16'h1234, 8'hA5, 0, 0, 8'h00, 2);
    vecs[2]  = mk(0, 0, 16'h1234, 8'h00, 0, 0, 8'hA5, 3);
    vecs[3]  = mk(1, 1, 16'h8000, 8'h01, 0, 0, 8'h00, 2);
    vecs[4]  = mk(1, 1, 16'h8001, 8'h02, 0, 0, 8'h00, 2);
    vecs[5]  = mk(1, 1, 16'h8002, 8'h03, 0, 0, 8'h00, 2);
    vecs[6]  = mk(1, 0, 16'h8000, 8'h00, 0, 0, 8'h01, 3);
    vecs[7]  = mk(1, 0, 16'h8001, 8'h00, 0, 0, 8'h02, 3);
    vecs[8]  = mk(1, 0, 16'h8002, 8'h00, 0, 0, 8'h03, 3);
    vecs[9]  = mk(1, 0, 16'hFFFF, 8'h00, 1, 1, 8'h00, 17);
    vecs[10] = mk(0, 0, 16'hFFFF, 8'h00, 0, 0, 8'h5A, 3);
    vecs[11] = mk(0, 1, 16'hFFFF, 8'hC3, 0, 0, 8'h00, 2);
    vecs[12] = mk(1, 0, 16'hFFFF, 8'h00, 0, 0, 8'hC3, 3);

    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_cs", ram_cs, 0);
    check("reset_m0_rdata", m0_rdata, 8'h00);
    check("reset_m1_ack", m1_ack, 0);

    // Reset while a read sits in WAIT: no ack for it, outputs drop at once.
    block = 1'b1;
    m0_we = 1'b0; m0_addr = 16'h0000; m0_req = 1'b1;
    repeat (4) @(negedge clk);
    check("wait_cs_high", ram_cs, 1);
    pulse_reset();

    for (int i = 0; i < 13; i++) begin
      start_txn(vecs[i]);
      wait_ack(vecs[i]);
      block = 1'b0;
      repeat (3) @(negedge clk);
    end

    // Stuck drdy after a read ack: nothing is granted until it drops.
    begin
      vec_t va, vb;
      va = mk(0, 0, 16'h0010, 8'h00, 0, 0, 8'h4A, 3);
      vb = mk(0, 0, 16'h0020, 8'h00, 0, 0, 8'h7A, 0);
      start_txn(va);
      wait_ack(va);
      stuck = 1'b1;
      start_txn(vb);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("stuck_no_grant", ram_cs, 0);
      end
      stuck = 1'b0;
      @(negedge clk);
      check("unstuck_idle", ram_cs, 0);
      @(negedge clk);
      check("unstuck_grant", ram_cs, 1);
      wait_ack(vb);
      repeat (3) @(negedge clk);
    end

    // Simultaneous held requests after reset: m0, m1, m0.
    pulse_reset();
    begin
      int   n0 = 0;
      int   n1 = 0;
      int   cyc = 0;
      push_exp(mk(0, 0, 16'h0010, 8'h00, 0, 0, 8'h4A, 0));
      push_exp(mk(1, 0, 16'h0020, 8'h00, 0, 0, 8'h7A, 0));
      push_exp(mk(0, 0, 16'h0010, 8'h00, 0, 0, 8'h4A, 0));
      m0_we = 1'b0; m0_addr = 16'h0010; m0_req = 1'b1;
      m1_we = 1'b0; m1_addr = 16'h0020; m1_req = 1'b1;
      while (!(n0 == 2 && n1 == 1) && cyc < 80) begin
        @(negedge clk);
        cyc++;
        if (m0_ack) begin
          n0++;
          if (n0 == 2) m0_req = 1'b0;
        end
        if (m1_ack) begin
          n1++;
          m1_req = 1'b0;
        end
      end
      check("rr_m0_acks", n0, 2);
      check("rr_m1_acks", n1, 1);
      m0_req = 1'b0;
      m1_req = 1'b0;
      repeat (4) @(negedge clk);
    end

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
